// File: rtl/farm_bridge_pkg.sv
// Shared types and constants for farm_bridge, the farm-request to AXI4-Lite bridge.
package farm_bridge_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;

  // Byte address of word index 0 in DRAM.
  localparam logic [ADDR_W-1:0] DRAM_BASE = 17'h10000;

  // Encoding of C_r_wb.
  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_AR = 3'd1,
    ST_RD_R  = 3'd2,
    ST_WR_AW = 3'd3,
    ST_WR_W  = 3'd4,
    ST_WR_B  = 3'd5,
    ST_DONE  = 3'd6
  } Bridge_sta;

  // Word index -> DRAM byte address (index 255 lands on 17'h103FC).
  function automatic logic [ADDR_W-1:0] idx_to_addr(input logic [IDX_W-1:0] idx);
    return DRAM_BASE + {{(ADDR_W-IDX_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/farm_bridge.sv
// farm_bridge: turns one-shot farm read/write requests into single AXI4-Lite
// transactions and returns a one-cycle completion pulse with read data.
// Optional feature macro: BRIDGE_RESP_CHK_EN -- when defined, a nonzero
// R_RESP/B_RESP at its handshake sets the sticky C_err flag; otherwise C_err is 0.
module farm_bridge
  import farm_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              C_in_valid,
  input  logic              C_r_wb,
  input  logic [IDX_W-1:0]  C_addr,
  input  logic [DATA_W-1:0] C_data_w,
  output logic              C_out_valid,
  output logic [DATA_W-1:0] C_data_r,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  input  logic              AW_READY,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY,
  output logic              C_err
);

  Bridge_sta         r_state;
  logic              r_ar_valid;
  logic [ADDR_W-1:0] r_ar_addr;
  logic              r_r_ready;
  logic              r_aw_valid;
  logic [ADDR_W-1:0] r_aw_addr;
  logic              r_w_valid;
  logic [DATA_W-1:0] r_w_data;
  logic              r_b_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_data_r;
  logic              r_err;

  // Transaction FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ar_valid  <= 1'b0;
      r_ar_addr   <= {ADDR_W{1'b0}};
      r_r_ready   <= 1'b0;
      r_aw_valid  <= 1'b0;
      r_aw_addr   <= {ADDR_W{1'b0}};
      r_w_valid   <= 1'b0;
      r_w_data    <= {DATA_W{1'b0}};
      r_b_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_r    <= {DATA_W{1'b0}};
      r_err       <= 1'b0;
    end else begin
      // Completion pulse and its data last exactly one cycle unless re-set below.
      r_out_valid <= 1'b0;
      r_data_r    <= {DATA_W{1'b0}};
      case (r_state)
        ST_IDLE: begin
          if (C_in_valid) begin
            case (C_r_wb)
              MODE_READ: begin
                r_ar_addr  <= idx_to_addr(C_addr);
                r_ar_valid <= 1'b1;
                r_state    <= ST_RD_AR;
              end
              MODE_WRITE: begin
                r_aw_addr  <= idx_to_addr(C_addr);
                r_w_data   <= C_data_w;
                r_aw_valid <= 1'b1;
                r_state    <= ST_WR_AW;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_RD_AR: begin
          if (AR_READY) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (R_VALID) begin
            r_r_ready   <= 1'b0;
            r_out_valid <= 1'b1;
            r_data_r    <= R_DATA;
`ifdef BRIDGE_RESP_CHK_EN
            if (R_RESP != 2'b00) r_err <= 1'b1;
`endif
            r_state     <= ST_DONE;
          end
        end
        ST_WR_AW: begin
          // W is only raised after AW has completed, so the two never overlap.
          if (AW_READY) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b1;
            r_state    <= ST_WR_W;
          end
        end
        ST_WR_W: begin
          if (W_READY) begin
            r_w_valid <= 1'b0;
            r_b_ready <= 1'b1;
            r_state   <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (B_VALID) begin
            r_b_ready   <= 1'b0;
            r_out_valid <= 1'b1;
`ifdef BRIDGE_RESP_CHK_EN
            if (B_RESP != 2'b00) r_err <= 1'b1;
`endif
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_ar_valid <= 1'b0;
          r_r_ready  <= 1'b0;
          r_aw_valid <= 1'b0;
          r_w_valid  <= 1'b0;
          r_b_ready  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BRIDGE_RESP_CHK_EN
  assign C_err = r_err;
`else
  // Response codes are deliberately ignored in this build.
  logic w_unused_resp;
  assign w_unused_resp = ^{R_RESP, B_RESP, r_err};
  assign C_err = 1'b0;
`endif

  assign C_out_valid = r_out_valid;
  assign C_data_r    = r_data_r;
  assign AR_VALID    = r_ar_valid;
  assign AR_ADDR     = r_ar_addr;
  assign R_READY     = r_r_ready;
  assign AW_VALID    = r_aw_valid;
  assign AW_ADDR     = r_aw_addr;
  assign W_VALID     = r_w_valid;
  assign W_DATA      = r_w_data;
  assign B_READY     = r_b_ready;

endmodule

// File: tb/tb_farm_bridge.sv
// Self-checking bench for farm_bridge: DRAM slave with configurable or random
// back-pressure, a word-indexed memory model, and one per-cycle compare process.
module tb_farm_bridge;

  logic        clk;
  logic        rst_n;
  logic        C_in_valid, C_r_wb;
  logic [7:0]  C_addr;
  logic [31:0] C_data_w;
  logic        C_out_valid;
  logic [31:0] C_data_r;
  logic        AR_VALID, AR_READY;
  logic [16:0] AR_ADDR;
  logic        R_VALID, R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        AW_VALID, AW_READY;
  logic [16:0] AW_ADDR;
  logic        W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        C_err;

  farm_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY),
    .C_err(C_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DRAM contents (word address = byte address / 4) and the farm-side model.
  logic [31:0] dram [0:32767];
  logic [31:0] model_mem [0:255];

  // Slave configuration.
  bit   bp = 1'b0;
  int   ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  logic [1:0] bresp_next = 2'b00;

  // Slave state.
  bit   rst_at_edge = 1'b0;
  int   ar_vcnt = 0, aw_vcnt = 0, w_vcnt = 0;
  bit   rd_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  int   rd_wait = 0, b_wait = 0;
  int   rd_widx = 0, wr_widx = 0;
  logic [31:0] wr_data = 32'h0;
  int   ar_issued = 0, aw_issued = 0;
  bit   err_model = 1'b0;

  // Expectations for the transaction in flight.
  bit          exp_pending = 1'b0;
  logic [31:0] exp_data = 32'h0;
  logic [16:0] exp_addr = 17'h0;
  logic [31:0] exp_wdata = 32'h0;
  int          out_count = 0;
  bit          abort = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return {16'hC0DE, 16'(w)};
  endfunction

  // DRAM slave: sample handshakes at the edge, drive new responses 1 time unit later.
  initial begin
    AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = 32'h0; R_RESP = 2'b00;
    AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = 2'b00;
    forever begin
      @(posedge clk);
      rst_at_edge = rst_n;
      if (!rst_n) begin
        ar_vcnt = 0; aw_vcnt = 0; w_vcnt = 0;
        rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        rd_wait = 0; b_wait = 0; err_model = 1'b0;
      end else begin
        if (rd_pend) rd_wait++;
        if (b_pend) b_wait++;
        if (R_VALID && R_READY) rd_pend = 0;
        if (B_VALID && B_READY) begin
          b_pend = 0;
`ifdef BRIDGE_RESP_CHK_EN
          if (B_RESP != 2'b00) err_model = 1'b1;
`endif
        end
        if (AR_VALID && AR_READY) begin
          rd_widx = int'(AR_ADDR[16:2]); rd_pend = 1; rd_wait = 0; ar_vcnt = 0; ar_issued++;
        end else if (AR_VALID) ar_vcnt++;
        if (AW_VALID && AW_READY) begin
          wr_widx = int'(AW_ADDR[16:2]); aw_got = 1; aw_vcnt = 0; aw_issued++;
        end else if (AW_VALID) aw_vcnt++;
        if (W_VALID && W_READY) begin
          wr_data = W_DATA; w_got = 1; w_vcnt = 0;
        end else if (W_VALID) w_vcnt++;
        if (aw_got && w_got && !b_pend) begin
          dram[wr_widx] = wr_data; aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
        end
      end
      #1;
      AR_READY = bp ? 1'($urandom_range(0, 1)) : (ar_vcnt >= ar_dly);
      AW_READY = bp ? 1'($urandom_range(0, 1)) : (aw_vcnt >= aw_dly);
      W_READY  = bp ? 1'($urandom_range(0, 1)) : (w_vcnt >= w_dly);
      R_VALID  = rd_pend && (R_VALID || (bp ? 1'($urandom_range(0, 1)) : (rd_wait >= r_dly)));
      R_DATA   = rd_pend ? dram[rd_widx] : 32'h0;
      if (!B_VALID) B_RESP = bresp_next;
      B_VALID  = b_pend && (B_VALID || (bp ? 1'($urandom_range(0, 1)) : (b_wait >= b_dly)));
    end
  end

  // Compare process: check every output against the model each cycle.
  bit          p_ar = 0, p_aw = 0, p_w = 0;
  logic [16:0] p_ar_addr, p_aw_addr;
  logic [31:0] p_w_data;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_at_edge) begin
        chk("rst_ctrl", {25'h0, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid, C_err}, 32'h0);
        chk("rst_ar_addr", {15'h0, AR_ADDR}, 32'h0);
        chk("rst_aw_addr", {15'h0, AW_ADDR}, 32'h0);
        chk("rst_w_data", W_DATA, 32'h0);
        chk("rst_data_r", C_data_r, 32'h0);
        exp_pending = 1'b0;
        p_ar = 0; p_aw = 0; p_w = 0;
      end else begin
        if (C_out_valid) begin
          out_count++;
          chk("spurious_done", {31'h0, exp_pending}, 32'h1);
          chk("done_data", C_data_r, exp_data);
          exp_pending = 1'b0;
        end else begin
          chk("idle_data_zero", C_data_r, 32'h0);
        end
        chk("c_err", {31'h0, C_err}, {31'h0, err_model});
        chk("aw_w_excl", {31'h0, AW_VALID & W_VALID}, 32'h0);
        if (AR_VALID) chk("ar_addr", {15'h0, AR_ADDR}, {15'h0, exp_addr});
        if (AW_VALID) chk("aw_addr", {15'h0, AW_ADDR}, {15'h0, exp_addr});
        if (W_VALID)  chk("w_data", W_DATA, exp_wdata);
        if (p_ar) chk("ar_hold", {AR_VALID, 14'h0, AR_ADDR}, {1'b1, 14'h0, p_ar_addr});
        if (p_aw) chk("aw_hold", {AW_VALID, 14'h0, AW_ADDR}, {1'b1, 14'h0, p_aw_addr});
        if (p_w)  chk("w_hold_valid", {31'h0, W_VALID}, 32'h1);
        if (p_w)  chk("w_hold_data", W_DATA, p_w_data);
        p_ar = AR_VALID && !AR_READY; p_ar_addr = AR_ADDR;
        p_aw = AW_VALID && !AW_READY; p_aw_addr = AW_ADDR;
        p_w  = W_VALID && !W_READY;   p_w_data = W_DATA;
      end
    end
  end

  // Issue one request; report latency (negedges from request), data and first address.
  task automatic do_req(input bit rd, input logic [7:0] idx, input logic [31:0] data,
                        input int spur, output int lat, output logic [31:0] got,
                        output logic [16:0] addr);
    lat = 0; got = 32'h0; addr = 17'h0;
    if (abort) return;
    @(negedge clk);
    exp_addr    = 17'(32'h10000 + 32'(idx) * 32'd4);
    exp_data    = rd ? model_mem[idx] : 32'h0;
    exp_wdata   = data;
    if (!rd) model_mem[idx] = data;
    exp_pending = 1'b1;
    C_in_valid = 1'b1; C_r_wb = rd; C_addr = idx; C_data_w = data;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) C_in_valid = 1'b0;
      if (spur != 0 && k == spur) begin
        C_in_valid = 1'b1; C_r_wb = 1'b0; C_addr = 8'h09; C_data_w = 32'hBAD0_0000;
      end
      if (spur != 0 && k == spur + 1) C_in_valid = 1'b0;
      if (addr == 17'h0 && AR_VALID) addr = AR_ADDR;
      if (addr == 17'h0 && AW_VALID) addr = AW_ADDR;
      if (C_out_valid) begin
        lat = k; got = C_data_r;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++; abort = 1'b1;
      $display("FAIL req_timeout idx %h got no completion expected one within 300 cycles", idx);
    end
  endtask

  int          lat, n_ar0, n_aw0, n_out0;
  logic [31:0] got;
  logic [16:0] addr;
  logic        exp_err_lit;

  initial begin
    rst_n = 1'b0; C_in_valid = 1'b0; C_r_wb = 1'b0; C_addr = 8'h0; C_data_w = 32'h0;
    for (int i = 0; i < 32768; i++) dram[i] = init_word(i);
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(16384 + i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Read of the deposit word, all DRAM handshakes immediate.
    dram[15'h40FF] = 32'h1234_5678; model_mem[255] = 32'h1234_5678;
    do_req(1'b1, 8'hFF, 32'h0, 0, lat, got, addr);
    chk("rd_ff_lat", 32'(lat), 32'd3);
    chk("rd_ff_addr", {15'h0, addr}, 32'h0001_03FC);
    chk("rd_ff_data", got, 32'h1234_5678);

    // Write with AW_READY delayed 4 cycles and W_READY delayed 2.
    aw_dly = 4; w_dly = 2;
    do_req(1'b0, 8'h05, 32'hDEAD_BEEF, 0, lat, got, addr);
    aw_dly = 0; w_dly = 0;
    chk("wr_05_lat", 32'(lat), 32'd10);
    chk("wr_05_addr", {15'h0, addr}, 32'h0001_0014);
    chk("wr_05_data_r", got, 32'h0);
    do_req(1'b0, 8'h06, 32'h0000_0066, 0, lat, got, addr);
    chk("wr_fast_lat", 32'(lat), 32'd4);

    // Spurious request while waiting in the read-data phase.
    r_dly = 4; n_ar0 = ar_issued; n_aw0 = aw_issued; n_out0 = out_count;
    do_req(1'b1, 8'h05, 32'h0, 3, lat, got, addr);
    repeat (6) @(negedge clk);
    r_dly = 0;
    chk("spur_lat", 32'(lat), 32'd7);
    chk("spur_data", got, 32'hDEAD_BEEF);
    chk("spur_ar_count", 32'(ar_issued - n_ar0), 32'd1);
    chk("spur_aw_count", 32'(aw_issued - n_aw0), 32'd0);
    chk("spur_out_count", 32'(out_count - n_out0), 32'd1);

    // Reset in the middle of a stalled read.
    ar_dly = 1000; exp_addr = 17'h1000C;
    @(negedge clk); C_in_valid = 1'b1; C_r_wb = 1'b1; C_addr = 8'h03;
    @(negedge clk); C_in_valid = 1'b0;
    @(negedge clk); chk("mid_ar_valid", {31'h0, AR_VALID}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ar_valid", {31'h0, AR_VALID}, 32'h0);
    chk("mid_rst_ar_addr", {15'h0, AR_ADDR}, 32'h0);
    rst_n = 1'b1; ar_dly = 0;
    do_req(1'b1, 8'h03, 32'h0, 0, lat, got, addr);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", got, 32'hC0DE_4003);

    // Error response on a write; flag must stick through later OK transactions.
    bresp_next = 2'b10;
    do_req(1'b0, 8'h20, 32'h0BAD_F00D, 0, lat, got, addr);
    bresp_next = 2'b00;
    do_req(1'b1, 8'h20, 32'h0, 0, lat, got, addr);
    chk("err_rd_data", got, 32'h0BAD_F00D);
    do_req(1'b0, 8'h21, 32'h1111_2222, 0, lat, got, addr);
`ifdef BRIDGE_RESP_CHK_EN
    exp_err_lit = 1'b1;
`else
    exp_err_lit = 1'b0;
`endif
    @(negedge clk);
    chk("c_err_sticky", {31'h0, C_err}, {31'h0, exp_err_lit});

    // Random back-pressure, mixed traffic over a small index set.
    bp = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ri;
      ri = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), ri, $urandom, 0, lat, got, addr);
    end
    bp = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_pending", {31'h0, exp_pending}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
